seq_det_run_ctrl: RTL and testbench

- Controller that runs one stimulus pass on a serial sequence detector (ports reset, i, out).
- Holds the detector in reset, feeds a LEN-bit stimulus word one bit per clock, and captures the detector's registered output per bit.
- Reports a per-bit hit map and a hit count, then parks the detector in reset.
- Sits between the evaluation harness (start/results) and one detector instance.

---
 rtl/seq_det_run_ctrl.sv | 126 ++++++++++++
 tb/tb_seq_det_run_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_det_run_ctrl.sv
// seq_det_run_ctrl: runs one LEN-bit stimulus pass on a serial sequence detector and collects its per-bit hits
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      run request (IDLE/DONE only), cancel of a run in progress
//   stim              stimulus word, stim[0] fed first, captured on accepted start
//   busy, done        run in progress, one-cycle completion pulse
//   det_rst, det_i    detector reset and serial input
//   det_out           detector registered output
//   hit_map, hit_cnt  det_out per stimulus bit, saturating count of hits
//   Optional (SEQ_DET_EXPECT_CHECK_EN): expect_bits in, err_cnt and pass out
module seq_det_run_ctrl #(
    parameter int LEN     = 16,
    parameter int CNT_W   = 5,
    parameter int RST_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN-1:0]   stim,
    output logic             busy,
    output logic             done,
    output logic             det_rst,
    output logic             det_i,
    input  logic             det_out,
    output logic [LEN-1:0]   hit_map,
    output logic [CNT_W-1:0] hit_cnt
`ifdef SEQ_DET_EXPECT_CHECK_EN
   ,input  logic [LEN-1:0]   expect_bits,
    output logic [CNT_W-1:0] err_cnt,
    output logic             pass
`endif
);
    localparam int IW = LEN > 1 ? $clog2(LEN) : 1;
    localparam int CW = RST_CYC > 1 ? $clog2(RST_CYC) : 1;
    typedef enum logic [2:0] {IDLE, RESET_DUT, FEED, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [IW-1:0] idx, idx_n, cap_pos;
    logic [CW-1:0] cnt, cnt_n;
    logic [LEN-1:0] shift, shift_n, hit_map_n;
    logic [CNT_W-1:0] hit_cnt_n;
    logic accept, cap;
`ifdef SEQ_DET_EXPECT_CHECK_EN
    logic [LEN-1:0] exp_q, exp_n;
    logic [CNT_W-1:0] err_cnt_n;
    logic pass_n;
`endif
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        idx_n     = '0;
        cnt_n     = '0;
        hit_map_n = hit_map;
        hit_cnt_n = hit_cnt;
        accept    = (state == IDLE || state == DONE) && start;
        // det_out lags det_i by one cycle, so each bit is captured one cycle late
        cap       = (state == FEED && idx != '0) || state == DRAIN;
        cap_pos   = state == DRAIN ? IW'(LEN - 1) : idx - 1'b1;
        case (state)
            IDLE, DONE: state_n = accept ? RESET_DUT : IDLE;
            RESET_DUT: begin
                cnt_n   = cnt + 1'b1;
                state_n = abort ? IDLE : (cnt == CW'(RST_CYC - 1) ? FEED : RESET_DUT);
            end
            FEED: begin
                idx_n   = idx + 1'b1;
                shift_n = shift >> 1;
                state_n = abort ? IDLE : (idx == IW'(LEN - 1) ? DRAIN : FEED);
            end
            DRAIN: state_n = abort ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
        if (accept) begin
            shift_n   = stim;
            hit_map_n = '0;
            hit_cnt_n = '0;
        end
        if (cap) begin
            hit_map_n[cap_pos] = det_out;
            if (det_out && hit_cnt != '1)
                hit_cnt_n = hit_cnt + 1'b1;
        end
`ifdef SEQ_DET_EXPECT_CHECK_EN
        exp_n     = accept ? expect_bits : exp_q;
        err_cnt_n = accept ? '0 : err_cnt;
        if (cap && det_out != exp_q[cap_pos] && err_cnt != '1)
            err_cnt_n = err_cnt + 1'b1;
        pass_n    = accept ? 1'b0 : (state_n == DONE ? err_cnt_n == '0 : pass);
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            shift   <= '0;
            hit_map <= '0;
            hit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            det_rst <= 1'b1;
            det_i   <= 1'b0;
`ifdef SEQ_DET_EXPECT_CHECK_EN
            exp_q   <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            shift   <= shift_n;
            hit_map <= hit_map_n;
            hit_cnt <= hit_cnt_n;
            // outputs are decoded from the next state so they are registered yet aligned with it
            busy    <= state_n == RESET_DUT || state_n == FEED || state_n == DRAIN;
            done    <= state_n == DONE;
            det_rst <= !(state_n == FEED || state_n == DRAIN);
            det_i   <= state_n == FEED && shift_n[0];
`ifdef SEQ_DET_EXPECT_CHECK_EN
            exp_q   <= exp_n;
            err_cnt <= err_cnt_n;
            pass    <= pass_n;
`endif
        end
    end
endmodule

// File: tb/tb_seq_det_run_ctrl.sv
// tb_seq_det_run_ctrl: scoreboard bench for seq_det_run_ctrl with a one-cycle-delay detector stub
module tb_seq_det_run_ctrl;
    logic clk = 1'b0;
    logic rst, start, abort, busy, done, det_rst, det_i, det_out;
    logic [15:0] stim, hit_map;
    logic [4:0] hit_cnt;
    logic dly, stub_one, prev_done;
`ifdef SEQ_DET_EXPECT_CHECK_EN
    logic [15:0] expect_bits;
    logic [4:0] err_cnt;
    logic pass_o;
`endif
    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;
    typedef struct {logic [15:0] map; logic [4:0] cnt; int cyc;} exp_t;
    exp_t sb[$];
    exp_t e;
    seq_det_run_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .stim(stim),
        .busy(busy), .done(done), .det_rst(det_rst), .det_i(det_i), .det_out(det_out),
        .hit_map(hit_map), .hit_cnt(hit_cnt)
`ifdef SEQ_DET_EXPECT_CHECK_EN
       ,.expect_bits(expect_bits), .err_cnt(err_cnt), .pass(pass_o)
`endif
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or posedge rst)
        if (rst) dly <= 1'b0;
        else dly <= det_rst ? 1'b0 : det_i;
    assign det_out = stub_one | dly;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", done, 1);
    endtask
    always @(negedge clk) begin
        if (!rst && done) begin
            if (prev_done) chk("done_one_cycle", prev_done, 0);
            if (sb.size() == 0) chk("unexpected_done", done, 0);
            else begin
                e = sb.pop_front();
                chk("sb_hit_map", hit_map, e.map);
                chk("sb_hit_cnt", hit_cnt, e.cnt);
                chk("sb_done_cycle", cyc, e.cyc);
            end
        end
        prev_done <= !rst && done;
    end
    initial begin
        logic [15:0] bits;
        rst = 1'b1; start = 1'b0; abort = 1'b0; stim = '0; stub_one = 1'b0;
`ifdef SEQ_DET_EXPECT_CHECK_EN
        expect_bits = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_det_rst", det_rst, 1);
        chk("rst_hit_cnt", hit_cnt, 0);
        rst = 1'b0;
        tick();
        stim = 16'h00FF; start = 1'b1;
        sb.push_back('{16'h00FF, 5'd8, cyc + 20});
        tick();
        start = 1'b0;
        chk("r1_busy", busy, 1);
        chk("r1_det_rst_hold", det_rst, 1);
        repeat (2) tick();
        chk("r1_det_rst_feed", det_rst, 0);
        for (int k = 0; k < 16; k++) begin
            bits[k] = det_i;
            tick();
        end
        chk("r1_det_i_seq", bits, 16'h00FF);
        chk("r1_drain_det_i", det_i, 0);
        tick();
        chk("r1_done", done, 1);
        tick();
        chk("r1_done_low", done, 0);
        chk("r1_idle_det_rst", det_rst, 1);
        chk("r1_hold_map", hit_map, 16'h00FF);
        stim = 16'hA5A5; start = 1'b1;
        sb.push_back('{16'hA5A5, 5'd8, cyc + 20});
        sb.push_back('{16'h0001, 5'd1, cyc + 40});
        tick();
        stim = 16'h0001;
        repeat (19) tick();
        chk("r2_done_a", done, 1);
        tick();
        chk("r2_direct_restart", busy, 1);
        repeat (19) tick();
        chk("r2_done_b", done, 1);
        start = 1'b0;
        repeat (2) tick();
        stim = 16'h0F0F; start = 1'b1;
        sb.push_back('{16'h0F0F, 5'd8, cyc + 20});
        tick();
        start = 1'b0;
        repeat (6) tick();
        stim = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        chk("r3_busy_ignored_start", busy, 1);
        wait_done(40);
        tick();
        stim = 16'h00FF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_det_rst", det_rst, 1);
        chk("arst_det_i", det_i, 0);
        chk("arst_hit_map", hit_map, 0);
        chk("arst_hit_cnt", hit_cnt, 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("arst_stay_idle", busy, 0);
        stub_one = 1'b1; stim = 16'h0000; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_det_rst", det_rst, 1);
        chk("abort_done", done, 0);
        chk("abort_hit_cnt", hit_cnt, 5);
        chk("abort_hit_map", hit_map, 16'h001F);
        repeat (3) tick();
        chk("abort_hold_map", hit_map, 16'h001F);
        stub_one = 1'b0;
`ifdef SEQ_DET_EXPECT_CHECK_EN
        stim = 16'h00FF; expect_bits = 16'h00FE; start = 1'b1;
        sb.push_back('{16'h00FF, 5'd8, cyc + 20});
        tick();
        start = 1'b0;
        wait_done(40);
        chk("x1_err_cnt", err_cnt, 1);
        chk("x1_pass", pass_o, 0);
        tick();
        expect_bits = 16'h00FF; start = 1'b1;
        sb.push_back('{16'h00FF, 5'd8, cyc + 20});
        tick();
        start = 1'b0;
        wait_done(40);
        chk("x2_err_cnt", err_cnt, 0);
        chk("x2_pass", pass_o, 1);
        tick();
`endif
        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
